// File: rtl/lifted_wavelet_reconstruction.sv
// Inverse 5/3 lifting stage: loads one 64-sample line as 32 low/high coefficient
// pairs, then undoes update and predict and streams reconstructed even/odd pairs.
module lifted_wavelet_reconstruction (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_valid,
  input  logic [15:0] data_in_low,
  input  logic [15:0] data_in_high,
  input  logic [7:0]  line_address,
  output logic        data_loading,
  output logic [15:0] low_address,
  output logic [15:0] high_address,
  output logic [15:0] data_out_even,
  output logic [15:0] data_out_odd,
  output logic        output_valid,
  output logic [15:0] even_address,
  output logic [15:0] odd_address,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CAL  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [4:0]  load_cnt;
  logic [5:0]  k;
  logic [7:0]  line_reg;
  logic [15:0] s_mem [32];
  logic [15:0] d_mem [32];

  logic        accept;
  logic        cal_write;
  logic        pair_out;
  logic        last_step;

  function automatic logic signed [17:0] sx(input logic [15:0] v);
    return {{2{v[15]}}, v};
  endfunction

  // Handshake: there is no back-pressure port. A beat is taken on any rising edge
  // where data_valid && data_loading; beats offered while data_loading=0 (CAL) are dropped.

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (data_valid) state_next = LOAD;
      LOAD:    if (data_valid && load_cnt == 5'd31) state_next = CAL;
      CAL:     if (k == 6'd32) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    data_loading = (state != CAL);
    accept       = data_valid && (state != CAL);
    cal_write    = (state == CAL) && !k[5];
    pair_out     = (state == CAL) && (k != 6'd0);
    last_step    = (state == CAL) && (k == 6'd32);
  end

  // Lifting datapath for step k: even sample k and the odd sample one step behind.
  logic [4:0]         k_idx;
  logic [4:0]         km1_idx;
  logic [15:0]        d_prev;
  logic signed [17:0] upd_sum;
  logic [15:0]        x_even;
  logic [15:0]        even_prev;
  logic [15:0]        even_cur;
  logic signed [17:0] pred_sum;
  logic [15:0]        x_odd;

  always_comb begin
    k_idx     = k[4:0];
    km1_idx   = k_idx - 5'd1;
    d_prev    = (k == 6'd0) ? d_mem[0] : d_mem[km1_idx];
    upd_sum   = sx(d_mem[k_idx]) + sx(d_prev) + 18'sd2;
    x_even    = 16'(sx(s_mem[k_idx]) - (upd_sum >>> 2));
    even_prev = s_mem[km1_idx];
    // Past the right edge the even sequence mirrors its last value.
    even_cur  = k[5] ? s_mem[31] : x_even;
    pred_sum  = sx(even_prev) + sx(even_cur);
    x_odd     = 16'(sx(d_mem[km1_idx]) + (pred_sum >>> 1));
  end

  // Coefficient storage; reconstructed even samples overwrite s in place.
  always_ff @(posedge clk) begin
    if (accept) begin
      s_mem[load_cnt] <= data_in_low;
      d_mem[load_cnt] <= data_in_high;
    end else if (cal_write) begin
      s_mem[k_idx] <= x_even;
    end
  end

  logic [15:0] line_base;
  logic [15:0] load_base;
  logic [4:0]  cnt_inc;

  always_comb begin
    line_base = {2'b00, line_reg, 6'b000000};
    load_base = (state == IDLE) ? {2'b00, line_address, 6'b000000} : line_base;
    cnt_inc   = load_cnt + 5'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt      <= 5'd0;
      k             <= 6'd0;
      line_reg      <= 8'd0;
      low_address   <= 16'd0;
      high_address  <= 16'd0;
      data_out_even <= 16'd0;
      data_out_odd  <= 16'd0;
      even_address  <= 16'd0;
      odd_address   <= 16'd0;
      output_valid  <= 1'b0;
      done          <= 1'b0;
    end else begin
      if (accept) begin
        load_cnt <= cnt_inc;
        if (state == IDLE) line_reg <= line_address;
        // After beat 31 the addresses hold at the last coefficient slot.
        if (load_cnt != 5'd31) begin
          low_address  <= load_base + {11'd0, cnt_inc};
          high_address <= load_base + 16'd32 + {11'd0, cnt_inc};
        end
      end
      if (state == CAL) k <= last_step ? 6'd0 : k + 6'd1;
      output_valid <= pair_out;
      done         <= last_step;
      if (pair_out) begin
        data_out_even <= even_prev;
        data_out_odd  <= x_odd;
        even_address  <= line_base + {10'd0, km1_idx, 1'b0};
        odd_address   <= line_base + {10'd0, km1_idx, 1'b1};
      end
    end
  end

endmodule
